// File: rtl/serial_frame_mon_pkg.sv
// Shared types and defaults for serial_frame_monitor: FSM state enum, default
// frame geometry and the first-mismatch helper used by the optional ERR_POS output.
package serial_frame_mon_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } mon_state_e;

    localparam int unsigned DEF_FRAME_LEN = 10;
    localparam logic [DEF_FRAME_LEN-1:0] DEF_PATTERN = 10'b1111110000;
    localparam int unsigned MAX_FRAME_LEN = 64;

    // Index of the first differing bit counted from the MSB of a len-bit field
    // (0 = first bit received); 0 when the fields are equal.
    function automatic int unsigned first_mismatch(
        input logic [MAX_FRAME_LEN-1:0] a,
        input logic [MAX_FRAME_LEN-1:0] b,
        input int unsigned              len
    );
        logic [MAX_FRAME_LEN-1:0] diff;
        int unsigned idx;
        logic        found;
        diff  = a ^ b;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_FRAME_LEN; i++) begin
            if (i < len && !found && diff[len-1-i]) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/serial_frame_monitor_if.sv
// Serial input and status/report bundle of serial_frame_monitor.
// ERR_POS exists only when SERIAL_FRAME_MON_ERRPOS_EN is defined.
interface serial_frame_monitor_if #(
    parameter int unsigned FRAME_LEN = serial_frame_mon_pkg::DEF_FRAME_LEN,
    parameter int unsigned CNT_W     = 8
);
    localparam int unsigned POS_W = $clog2(FRAME_LEN);

    logic                 SER_IN;
    logic                 LOCKED;
    logic                 FRAME_VLD;
    logic                 FRAME_ERR;
    logic [FRAME_LEN-1:0] FRAME_Q;
    logic [CNT_W-1:0]     FRAME_CNT;
    logic [CNT_W-1:0]     ERR_CNT;
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
    logic [POS_W-1:0]     ERR_POS;
`endif

    modport master (
        output SER_IN,
        input  LOCKED, FRAME_VLD, FRAME_ERR, FRAME_Q, FRAME_CNT, ERR_CNT
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
        , input ERR_POS
`endif
    );

    modport slave (
        input  SER_IN,
        output LOCKED, FRAME_VLD, FRAME_ERR, FRAME_Q, FRAME_CNT, ERR_CNT
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
        , output ERR_POS
`endif
    );

endinterface

// File: rtl/serial_frame_monitor_frame_shreg.sv
// frame_shreg: FRAME_LEN-bit serial-in shift register; exposes the post-shift
// window and its equality against PATTERN for use on the same edge.
module frame_shreg
    import serial_frame_mon_pkg::*;
#(
    parameter int unsigned          FRAME_LEN = DEF_FRAME_LEN,
    parameter logic [FRAME_LEN-1:0] PATTERN   = DEF_PATTERN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_in,
    output logic [FRAME_LEN-1:0] window,
    output logic                 match
);

    logic [FRAME_LEN-1:0] shreg_q;
    logic [FRAME_LEN-1:0] shreg_d;
    logic                 unused_oldest;

    always_comb begin
        shreg_d = {shreg_q[FRAME_LEN-2:0], ser_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // The oldest stored bit is shifted out before it is ever part of a window.
    assign unused_oldest = shreg_q[FRAME_LEN-1];
    assign window        = shreg_d;
    assign match         = (shreg_d == PATTERN);

endmodule

// File: rtl/serial_frame_monitor.sv
// Serial frame monitor: hunts for PATTERN, then checks every FRAME_LEN-bit frame.
// Optional ERR_POS output enabled by defining SERIAL_FRAME_MON_ERRPOS_EN.
module serial_frame_monitor
    import serial_frame_mon_pkg::*;
#(
    parameter int unsigned          FRAME_LEN = DEF_FRAME_LEN,
    parameter logic [FRAME_LEN-1:0] PATTERN   = DEF_PATTERN,
    parameter int unsigned          MAX_ERR   = 2,
    parameter int unsigned          CNT_W     = 8
) (
    input logic                   CLK,
    input logic                   RST,
    serial_frame_monitor_if.slave bus
);

    localparam int unsigned       BIT_W      = $clog2(FRAME_LEN);
    localparam int unsigned       CONS_W     = $clog2(MAX_ERR + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(FRAME_LEN - 1);
    localparam logic [CONS_W-1:0] CONS_LIMIT = CONS_W'(MAX_ERR);

    logic [FRAME_LEN-1:0] window;
    logic                 match;

    mon_state_e           state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CONS_W-1:0]    cons_q, cons_d;
    logic                 locked_q, locked_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;
    logic [FRAME_LEN-1:0] frm_q, frm_d;
    logic [CNT_W-1:0]     good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]     bad_cnt_q, bad_cnt_d;
    logic [CONS_W-1:0]    cons_inc;
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
    logic [BIT_W-1:0]     err_pos_q, err_pos_d;
`endif

    frame_shreg #(
        .FRAME_LEN (FRAME_LEN),
        .PATTERN   (PATTERN)
    ) u_shreg (
        .clk    (CLK),
        .rst    (RST),
        .ser_in (bus.SER_IN),
        .window (window),
        .match  (match)
    );

    assign cons_inc = cons_q + CONS_W'(1);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cons_d     = cons_q;
        vld_d      = 1'b0;
        err_d      = 1'b0;
        frm_d      = frm_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
        err_pos_d  = err_pos_q;
`endif
        unique case (state_q)
            HUNT: begin
                if (match) begin
                    state_d    = LOCK;
                    vld_d      = 1'b1;
                    frm_d      = window;
                    bit_cnt_d  = '0;
                    good_cnt_d = (good_cnt_q == '1) ? good_cnt_q : good_cnt_q + CNT_W'(1);
                end
            end
            LOCK: begin
                bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    frm_d = window;
                    if (match) begin
                        vld_d      = 1'b1;
                        cons_d     = '0;
                        good_cnt_d = (good_cnt_q == '1) ? good_cnt_q : good_cnt_q + CNT_W'(1);
                    end else begin
                        err_d     = 1'b1;
                        bad_cnt_d = (bad_cnt_q == '1) ? bad_cnt_q : bad_cnt_q + CNT_W'(1);
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
                        err_pos_d = BIT_W'(first_mismatch(MAX_FRAME_LEN'(window),
                                                          MAX_FRAME_LEN'(PATTERN), FRAME_LEN));
`endif
                        if (cons_inc == CONS_LIMIT) begin
                            state_d = HUNT;
                            cons_d  = '0;
                        end else begin
                            cons_d  = cons_inc;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            cons_q     <= '0;
            locked_q   <= 1'b0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            frm_q      <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
            err_pos_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cons_q     <= cons_d;
            locked_q   <= locked_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            frm_q      <= frm_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
            err_pos_q  <= err_pos_d;
`endif
        end
    end

    assign bus.LOCKED    = locked_q;
    assign bus.FRAME_VLD = vld_q;
    assign bus.FRAME_ERR = err_q;
    assign bus.FRAME_Q   = frm_q;
    assign bus.FRAME_CNT = good_cnt_q;
    assign bus.ERR_CNT   = bad_cnt_q;
`ifdef SERIAL_FRAME_MON_ERRPOS_EN
    assign bus.ERR_POS   = err_pos_q;
`endif

endmodule

// File: doc/serial_frame_monitor.md
# serial_frame_monitor

Consumes the 1-bit serial stream produced by the counter/ROM/mux pattern generator, one bit per clock. It deserialises the stream into fixed-length frames, acquires frame alignment against a known pattern, and then checks every subsequent frame. It reports lock status, per-frame valid and error pulses, and saturating frame and error counters. It sits directly downstream of the generator's single-bit output and gives the lab bench a self-checking receiver in place of manual waveform inspection.

## Interface
- FRAME_LEN, 10: bits per frame; one full BCD count period of the generator.
- PATTERN, 10'b1111110000: expected frame; the MSB is the first bit received.
- MAX_ERR, 2: consecutive bad frames that cause loss of lock.
- CNT_W, 8: width of the frame and error counters.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- SER_IN  in  1  serial data from the generator; sampled every rising edge.
- LOCKED  out  1  high while frame alignment is held.
- FRAME_VLD  out  1  one-cycle pulse when a frame completes and matches PATTERN.
- FRAME_ERR  out  1  one-cycle pulse when a frame completes and does not match PATTERN.
- FRAME_Q  out  FRAME_LEN  last completed frame; first-received bit in the MSB.
- FRAME_CNT  out  CNT_W  good frames since reset; saturates at all-ones.
- ERR_CNT  out  CNT_W  bad frames since reset; saturates at all-ones.

## Operation
- Reset values: all outputs 0, state HUNT, shift register 0, bit counter 0, consecutive-error counter 0.
- Shift register: FRAME_LEN bits. Every edge it shifts left by one and SER_IN enters at the LSB, in all states.
- State HUNT:
  - LOCKED = 0.
  - Each edge, the post-shift window is compared against PATTERN.
  - On a match: go to LOCK, pulse FRAME_VLD, load FRAME_Q with the window, increment FRAME_CNT, clear the bit counter.
  - Windows containing bits from before reset count as 0, so a match needs at least FRAME_LEN post-reset samples of PATTERN.
- State LOCK:
  - LOCKED = 1.
  - The bit counter runs 0..FRAME_LEN-1, increments every edge and wraps to 0.
  - On the edge where the counter is FRAME_LEN-1, the post-shift window is a complete frame and loads FRAME_Q.
  - If the frame matches: pulse FRAME_VLD, increment FRAME_CNT, clear the consecutive-error counter.
  - If it does not match: pulse FRAME_ERR, increment ERR_CNT, increment the consecutive-error counter.
  - When the consecutive-error counter reaches MAX_ERR: go to HUNT on that edge, LOCKED falls the same edge, clear the consecutive-error counter.
- No frame check is made in LOCK between frame boundaries.
- Counters stick at 2^CNT_W-1 and never wrap.
- FRAME_VLD and FRAME_ERR are never high together.

## Timing
- All outputs are registered.
- Latency: FRAME_VLD/FRAME_ERR rise on the same edge that samples the last bit of a frame; FRAME_Q is valid from that edge.
- After reset: the first lock occurs at the earliest on the edge sampling the FRAME_LEN-th post-reset bit.
- Frame cadence in LOCK: one FRAME_VLD or FRAME_ERR pulse every FRAME_LEN cycles, exactly.
- Loss of lock: LOCKED falls on the edge of the MAX_ERR-th consecutive bad frame. Re-acquisition is possible on any later edge, including the next one.
- RST asserted mid-frame or in LOCK: the next edge applies full reset values. RST wins over a simultaneous match or frame completion.

## Configuration
- Macro: SERIAL_FRAME_MON_ERRPOS_EN.
- Defined: adds output ERR_POS, width $clog2(FRAME_LEN).
  - Loaded on each FRAME_ERR edge with the index of the first mismatching bit, counted from the MSB (0 = first bit received).
  - Holds its value otherwise; resets to 0.
- Undefined: ERR_POS port and its logic are absent; all other behaviour is identical.

## Structure
- Package serial_frame_mon_pkg holds:
  - the state enum (HUNT, LOCK);
  - default FRAME_LEN and PATTERN constants;
  - a function computing the first-mismatch index.
- One sub-module, frame_shreg: FRAME_LEN shift register plus equality compare against PATTERN. Outputs are the window and a match flag. The top level owns the FSM and counters.

## Test plan
- Reset then stream 1111110000 repeated: LOCKED rises on the 10th edge after reset; FRAME_VLD pulses every 10 cycles; FRAME_CNT = 5 after 50 cycles; ERR_CNT = 0.
- Locked, then corrupt one frame to 1111010000: one FRAME_ERR pulse; ERR_CNT = 1; LOCKED stays 1; the next clean frame pulses FRAME_VLD; ERR_POS = 4 when the macro is enabled.
- Locked, then two consecutive corrupted frames: LOCKED falls on the 2nd FRAME_ERR edge; resuming the clean stream re-locks within 10 cycles.
- Stream starting mid-pattern (0000111111 then repeating): no lock before a full 1111110000 window; lock occurs at exactly the 10th bit of the first aligned frame.
- Assert RST for one cycle mid-frame while locked: all outputs 0 after the edge; relock takes a fresh 10 matching bits.
- Force FRAME_CNT to 8'hFF (long run, CNT_W = 8): after 260 good frames FRAME_CNT holds 8'hFF with no wrap.
